// File: rtl/pa32_share_sched.sv
// pa32_share_sched
//   Shares one 32-bit parallel-prefix adder between NREQ requesters.
//   Round-robin arbitration picks a beat, which flows issue reg -> adder ->
//   result reg. A requester can lock the adder across several beats (a
//   multi-word add); the carry-out of each beat leaving the issue stage is
//   kept in carry_reg so a following beat may chain from it.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester beat handshake (ready one-hot or 0)
//   req_a/req_b            packed operands, requester i at [32i+31:32i]
//   req_cin                carry-in used when req_chain[i]=0
//   req_chain              1: take carry-in from the internal carry register
//   req_last               1: final beat of a transaction, releases the lock
//   rsp_valid/rsp_ready    result handshake
//   rsp_id/rsp_sum/rsp_cout  requester index, sum and carry-out of the beat
module pa32_share_sched #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_chain,
  input  logic [NREQ-1:0]      req_last,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   rr_ptr, owner;
  logic            carry_reg;

  logic            iss_v, iss_cin, iss_chain;
  logic [IW-1:0]   iss_id;
  logic [31:0]     iss_a, iss_b;

  logic            res_v, res_cout;
  logic [IW-1:0]   res_id;
  logic [31:0]     res_sum;

  logic            adv_r, adv_i, accept, sel_found;
  logic [IW-1:0]   sel_id;
  logic            sel_last;
  int              idx;

  logic            cin_eff, add_cout;
  logic [31:0]     add_sum, add_p0, add_g, add_p, add_gn, add_pn;

  assign adv_r = !res_v || rsp_ready;
  assign adv_i = !iss_v || adv_r;

  // Candidate selection: in LOCK only the owner may be granted; in ARB the
  // first valid requester after rr_ptr (wrapping) wins.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    idx       = 0;
    if (state == LOCK) begin
      sel_id    = owner;
      sel_found = req_valid[owner];
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!sel_found && req_valid[idx]) begin
          sel_id    = IW'(idx);
          sel_found = 1'b1;
        end
      end
    end
  end

  // Ready is masked during reset so the outputs sit at their reset values
  // even while requesters keep valid high.
  always_comb begin
    accept    = sel_found && adv_i && !rst;
    sel_last  = req_last[sel_id];
    req_ready = '0;
    if (accept) req_ready[sel_id] = 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (accept && !sel_last) next_state = LOCK;
      LOCK:    if (accept && sel_last)  next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= next_state;
  end

  // Kogge-Stone prefix adder on the issue-reg contents. The carry-in is
  // folded into the bit-0 generate so the prefix tree yields every carry.
  always_comb begin
    cin_eff   = iss_chain ? carry_reg : iss_cin;
    add_p0    = iss_a ^ iss_b;
    add_g     = iss_a & iss_b;
    add_g[0]  = add_g[0] | (add_p0[0] & cin_eff);
    add_p     = add_p0;
    add_gn    = '0;
    add_pn    = '0;
    for (int d = 1; d < 32; d = d * 2) begin
      add_gn = add_g;
      add_pn = add_p;
      for (int i = d; i < 32; i++) begin
        add_gn[i] = add_g[i] | (add_p[i] & add_g[i-d]);
        add_pn[i] = add_p[i] & add_p[i-d];
      end
      add_g = add_gn;
      add_p = add_pn;
    end
    add_sum  = add_p0 ^ {add_g[30:0], cin_eff};
    add_cout = add_g[31];
  end

  // Pipe registers. carry_reg follows the beat that leaves the issue reg, so
  // a chained beat entering the issue reg on that same edge sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v     <= 1'b0;
      iss_id    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_cin   <= 1'b0;
      iss_chain <= 1'b0;
      res_v     <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      carry_reg <= 1'b0;
      rr_ptr    <= IW'(NREQ - 1);
      owner     <= '0;
    end else begin
      if (adv_i) begin
        iss_v <= accept;
        if (accept) begin
          iss_id    <= sel_id;
          iss_a     <= req_a[32*sel_id +: 32];
          iss_b     <= req_b[32*sel_id +: 32];
          iss_cin   <= req_cin[sel_id];
          iss_chain <= req_chain[sel_id];
        end
      end
      if (adv_r) res_v <= iss_v;
      if (adv_r && iss_v) begin
        res_id    <= iss_id;
        res_sum   <= add_sum;
        res_cout  <= add_cout;
        carry_reg <= add_cout;
      end
      if (accept) rr_ptr <= sel_id;
      if (accept && state == ARB && !sel_last) owner <= sel_id;
    end
  end

  assign rsp_valid = res_v;
  assign rsp_id    = res_id;
  assign rsp_sum   = res_sum;
  assign rsp_cout  = res_cout;

endmodule

// File: tb/tb_pa32_share_sched.sv
// tb_pa32_share_sched
//   Scoreboard bench for pa32_share_sched (NREQ=4). Each cycle the stimulus
//   side predicts the grant from a round-robin/lock model and, on accept,
//   pushes the expected response computed with plain 33-bit arithmetic.
//   A separate monitor compares every presented response against the
//   queue head and checks its arrival cycle.
module tb_pa32_share_sched;

  localparam int NREQ = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid, req_ready, req_cin, req_chain, req_last;
  logic [127:0]  req_a, req_b;
  logic          rsp_valid, rsp_ready, rsp_cout;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_sum;

  pa32_share_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_chain(req_chain), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_rr;
  bit  m_locked;
  int  m_owner;
  bit  m_carry;
  int  acc_cnt, rsp_cnt, last_pop;
  bit  head_seen;
  bit  mon_en = 1'b0;

  // Model reset: pointer so that req 0 is searched first, no lock, carry 0
  task automatic modelReset();
    sb.delete();
    m_rr      = NREQ - 1;
    m_locked  = 1'b0;
    m_owner   = 0;
    m_carry   = 1'b0;
    acc_cnt   = 0;
    rsp_cnt   = 0;
    last_pop  = -100;
    head_seen = 1'b0;
  endtask

  // Predict the grant, compare it, and on accept push the expected result
  task automatic checkOutput();
    int         win;
    bit         adv;
    logic [3:0] exp_ready;
    logic [32:0] tot;
    bit         cin_eff;
    exp_t       e;
    win = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) win = m_owner;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (win < 0 && req_valid[j]) win = j;
      end
    end
    adv = ((acc_cnt - rsp_cnt) < 2) || rsp_ready;
    exp_ready = 4'b0000;
    if (win >= 0 && adv) exp_ready[win] = 1'b1;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("[TB] FAIL grant cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
    end
    if (win >= 0 && adv) begin
      cin_eff = req_chain[win] ? m_carry : req_cin[win];
      tot = {1'b0, req_a[32*win +: 32]} + {1'b0, req_b[32*win +: 32]} + {32'd0, cin_eff};
      e.id   = 2'(win);
      e.sum  = tot[31:0];
      e.cout = tot[32];
      e.acc  = cyc;
      sb.push_back(e);
      m_carry = tot[32];
      m_rr    = win;
      if (!m_locked && !req_last[win]) begin
        m_locked = 1'b1;
        m_owner  = win;
      end else if (m_locked && req_last[win]) begin
        m_locked = 1'b0;
      end
      acc_cnt++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] cin,
                               input logic [3:0] chain, input logic [3:0] last,
                               input logic [127:0] a, input logic [127:0] b,
                               input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_cin   = cin;
    req_chain = chain;
    req_last  = last;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkReset(input string tag);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL %s req_ready: got %b expected 0000", tag, req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s rsp_valid: got %b expected 0", tag, rsp_valid);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_sum !== 32'd0 || rsp_cout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s rsp_data: got id=%0d sum=%h cout=%b expected 0/0/0",
               tag, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks every presented response against the queue head, and
  // its first-valid cycle against accept+2 or one past the previous drain.
  always @(negedge clk) begin
    #1;
    if (mon_en && !rst && rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL spurious_rsp cyc=%0d: got id=%0d sum=%h, expected none", cyc, rsp_id, rsp_sum);
      end else begin
        if (rsp_id !== sb[0].id || rsp_sum !== sb[0].sum || rsp_cout !== sb[0].cout) begin
          errors++;
          $display("[TB] FAIL rsp cyc=%0d: got id=%0d sum=%h cout=%b expected id=%0d sum=%h cout=%b",
                   cyc, rsp_id, rsp_sum, rsp_cout, sb[0].id, sb[0].sum, sb[0].cout);
        end
        if (!head_seen) begin
          int exp_c;
          head_seen = 1'b1;
          exp_c = (sb[0].acc + 2 > last_pop + 1) ? sb[0].acc + 2 : last_pop + 1;
          checks++;
          if (cyc != exp_c) begin
            errors++;
            $display("[TB] FAIL latency: rsp first valid at cyc %0d expected cyc %0d", cyc, exp_c);
          end
        end
        if (rsp_ready) begin
          void'(sb.pop_front());
          rsp_cnt++;
          last_pop  = cyc;
          head_seen = 1'b0;
        end
      end
    end
  end

  logic [127:0] va, vb;

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_cin   = '0;
    req_chain = '0;
    req_last  = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    checkReset("reset_init");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    modelReset();
    mon_en    = 1'b1;

    // Single add on req 0: 1 + FFFFFFFF -> 0 with carry-out
    va = '0; vb = '0;
    va[31:0] = 32'h0000_0001;
    vb[31:0] = 32'hFFFF_FFFF;
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);
    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);

    // 64-bit chained add on req 2, req 1 kept waiting behind the lock
    va = '0; vb = '0;
    va[95:64] = 32'hFFFF_FFFF;
    vb[95:64] = 32'hFFFF_FFFF;
    va[63:32] = 32'h1234_5678;
    vb[63:32] = 32'h0000_1111;
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b1011, va, vb, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);
    va[95:64] = 32'h0; vb[95:64] = 32'h0;
    applyStimulus(4'b0110, 4'b0000, 4'b0100, 4'b1111, va, vb, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);
    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);

    // All four streaming single-beat adds
    for (int i = 0; i < 12; i++) begin
      va = {rnd32(), rnd32(), rnd32(), rnd32()};
      vb = {rnd32(), rnd32(), rnd32(), rnd32()};
      applyStimulus(4'b1111, 4'($urandom), 4'b0000, 4'b1111, va, vb, 1'b1);
    end

    // Backpressure: three requesters streaming, consumer stalls 5 cycles
    for (int i = 0; i < 12; i++) begin
      va = {rnd32(), rnd32(), rnd32(), rnd32()};
      vb = {rnd32(), rnd32(), rnd32(), rnd32()};
      applyStimulus(4'b0111, 4'($urandom), 4'b0000, 4'b1111, va, vb, (i < 2 || i >= 7));
    end
    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);

    // Reset mid-lock with a result held under backpressure
    va = {4{32'h8000_0000}};
    vb = {4{32'h8000_0001}};
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, va, vb, 1'b0);
    repeat (3) applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b0);
    @(posedge clk);
    #3;
    req_valid = 4'b1111;
    mon_en    = 1'b0;
    rst       = 1'b1;
    #1;
    checkReset("reset_async");
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    modelReset();
    mon_en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      va = {rnd32(), rnd32(), rnd32(), rnd32()};
      vb = {rnd32(), rnd32(), rnd32(), rnd32()};
      applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);
    end

    // Randomized traffic with locks, chaining, gaps and backpressure
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] v, ch, la;
      for (int r = 0; r < 4; r++) begin
        v[r]  = ($urandom_range(0, 99) < 55);
        ch[r] = ($urandom_range(0, 99) < 30);
        la[r] = ($urandom_range(0, 99) < 50);
      end
      va = {rnd32(), rnd32(), rnd32(), rnd32()};
      vb = {rnd32(), rnd32(), rnd32(), rnd32()};
      applyStimulus(v, 4'($urandom), ch, la, va, vb, ($urandom_range(0, 99) < 70));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1111, va, vb, 1'b1);
    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d responses outstanding expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
